// File: rtl/mem_ctrl.sv
// Bridges a 32-bit fetch port and a 32-bit data port onto a byte-wide synchronous RAM.
// Each word access is serialised into four byte beats; the data port has priority.
module mem_ctrl #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_inst,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_sel,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-3:0] word_q;
  logic [31:0]       wdata_q;
  logic [3:0]        sel_q;
  logic              is_mem_q;
  logic [23:0]       rbuf_q;

  logic              accept;
  logic              pick_mem;
  logic [ADDR_W-3:0] req_word;
  logic [1:0]        beat;

  assign beat     = cnt_q[1:0];
  assign pick_mem = mem_req;
  assign accept   = (state_q == StIdle) && (mem_req || if_req);
  assign req_word = pick_mem ? mem_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];

  // Byte-lane and out-of-range address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W], if_addr[1:0],
                              mem_addr[31:ADDR_W], mem_addr[1:0]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (mem_req) begin
          state_d = mem_we ? StWrite : StRead;
        end else if (if_req) begin
          state_d = StRead;
        end
      end
      // Beat 4 only collects the last byte returned for beat 3.
      StRead: begin
        if (cnt_q == 3'd4) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StWrite: begin
        if (cnt_q == 3'd3) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request latch and read-word assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      is_mem_q  <= 1'b0;
      rbuf_q    <= '0;
      if_inst   <= '0;
      mem_rdata <= '0;
    end else begin
      if (accept) begin
        word_q   <= req_word;
        is_mem_q <= pick_mem;
        wdata_q  <= pick_mem ? mem_wdata : '0;
        sel_q    <= pick_mem ? mem_sel : '0;
      end
      if (state_q == StRead) begin
        // RAM data lags the address by one cycle, so beat k lands byte k-1.
        case (cnt_q)
          3'd1: rbuf_q[7:0]   <= ram_dout;
          3'd2: rbuf_q[15:8]  <= ram_dout;
          3'd3: rbuf_q[23:16] <= ram_dout;
          3'd4: begin
            if (is_mem_q) begin
              mem_rdata <= {ram_dout, rbuf_q};
            end else begin
              if_inst <= {ram_dout, rbuf_q};
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs
  always_comb begin
    ram_addr = '0;
    ram_we   = 1'b0;
    ram_din  = '0;
    if_done  = 1'b0;
    mem_done = 1'b0;
    unique case (state_q)
      StRead: begin
        if (!cnt_q[2]) begin
          ram_addr = {word_q, beat};
        end
      end
      StWrite: begin
        ram_addr = {word_q, beat};
        ram_we   = sel_q[beat];
        ram_din  = wdata_q[{beat, 3'b000} +: 8];
      end
      StDone: begin
        if_done  = !is_mem_q;
        mem_done = is_mem_q;
      end
      default: ;
    endcase
  end

  ram_we_only_in_write: assert property (@(posedge clk) disable iff (rst)
    ram_we |-> (state_q == StWrite));
  done_exclusive: assert property (@(posedge clk) !(if_done && mem_done));
  done_single_cycle: assert property (@(posedge clk) disable iff (rst)
    (if_done || mem_done) |=> !(if_done || mem_done));

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed vector table, corner-case sequences and
// randomized traffic checked against a byte-array model of RAM contents.
`timescale 1ns/1ps
module tb_mem_ctrl;

  localparam int unsigned AW    = 17;
  localparam logic [31:0] AMASK = (32'd1 << AW) - 32'd1;

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, mem_req, mem_we;
  logic [31:0]   if_addr, mem_addr, mem_wdata;
  logic [3:0]    mem_sel;
  logic [31:0]   if_inst, mem_rdata;
  logic          if_done, mem_done;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_din;
  logic [7:0]    ram_dout;

  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [7:0]    pl_data;

  logic [7:0]    ram     [0:(1<<AW)-1];
  logic [7:0]    ref_mem [0:(1<<AW)-1];
  logic [31:0]   last_if, last_mem;
  logic [AW-1:0] addr_log [4];
  bit            we_seen;
  vec_t          vecs[$];
  int            total = 0;
  int            bad   = 0;

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_inst   (if_inst),
    .if_done   (if_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_sel   (mem_sel),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  // Byte-wide synchronous RAM with a preload port for the bench.
  always @(posedge clk) begin
    ram_dout <= ram[ram_addr];
    if (ram_we) ram[ram_addr] <= ram_din;
    if (pl_en) ram[pl_addr] <= pl_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pre_byte(input int unsigned a);
    case (a)
      32'h10:         return 8'h13;
      32'h11:         return 8'h05;
      32'h12, 32'h13: return 8'h00;
      32'h20:         return 8'h11;
      32'h21:         return 8'h22;
      32'h22:         return 8'h33;
      32'h23:         return 8'h44;
      32'h24:         return 8'h55;
      32'h25:         return 8'h66;
      32'h26:         return 8'h77;
      32'h27:         return 8'h88;
      default:        return 8'(a * 37 + 11);
    endcase
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int unsigned b;
    b = int'(a & AMASK & ~32'd3);
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic add_vec(input bit m, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] e, input string n);
    vec_t v;
    v.is_mem = m;
    v.we     = w;
    v.addr   = a;
    v.wdata  = d;
    v.sel    = s;
    v.exp    = e;
    v.name   = n;
    vecs.push_back(v);
  endtask

  // Waits for the done pulse of one port; lat stays -1 if the budget runs out.
  task automatic wait_done(input bit m, output int lat, output logic [31:0] got,
                           output bit other);
    lat     = -1;
    other   = 1'b0;
    we_seen = 1'b0;
    got     = '0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n <= 4) addr_log[n-1] = ram_addr;
      we_seen = we_seen | ram_we;
      if (m ? if_done : mem_done) other = 1'b1;
      if (m ? mem_done : if_done) begin
        lat = n;
        got = m ? mem_rdata : if_inst;
        break;
      end
    end
  endtask

  task automatic run_txn(input bit m, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] got);
    int          lat;
    bit          other;
    int unsigned b;
    if (m) begin
      mem_req   = 1'b1;
      mem_we    = w;
      mem_addr  = a;
      mem_wdata = d;
      mem_sel   = s;
    end else begin
      if_req  = 1'b1;
      if_addr = a;
    end
    wait_done(m, lat, got, other);
    mem_req = 1'b0;
    if_req  = 1'b0;
    mem_we  = 1'b0;
    check("latency", 32'(lat), w ? 32'd5 : 32'd6);
    check("wrong_port_done", 32'(other), 32'd0);
    check("ram_we_activity", 32'(we_seen), 32'(w && (s != 4'b0000)));
    tick();
    check("done_one_cycle", {30'd0, if_done, mem_done}, 32'd0);
    b = int'(a & AMASK & ~32'd3);
    if (w) begin
      for (int k = 0; k < 4; k++) if (s[k]) ref_mem[b+k] = d[8*k +: 8];
    end else if (m) begin
      last_mem = model_word(a);
    end else begin
      last_if = model_word(a);
    end
    check("if_inst_hold", if_inst, last_if);
    check("mem_rdata_hold", mem_rdata, last_mem);
  endtask

  initial begin
    logic [31:0] got;
    int          lat;
    bit          other;
    bit          any_done;

    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_sel   = '0;
    pl_en     = 1'b0;
    pl_addr   = '0;
    pl_data   = '0;
    last_if   = '0;
    last_mem  = '0;

    for (int i = 0; i < 512; i++) begin
      pl_en      = 1'b1;
      pl_addr    = AW'(i);
      pl_data    = pre_byte(i);
      ref_mem[i] = pre_byte(i);
      tick();
    end
    pl_en = 1'b0;
    tick();

    check("rst_if_done", 32'(if_done), 32'd0);
    check("rst_mem_done", 32'(mem_done), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_din", 32'(ram_din), 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    tick();

    add_vec(0, 0, 32'h0000_0010, 32'h0,         4'b0000, 32'h0000_0513, "fetch_10");
    add_vec(0, 0, 32'h0000_0013, 32'h0,         4'b0000, 32'h0000_0513, "fetch_13");
    add_vec(1, 1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 32'h0,         "write_20");
    add_vec(1, 0, 32'h0000_0020, 32'h0,         4'b0000, 32'h44BB_22DD, "read_20");
    add_vec(1, 1, 32'h0000_0024, 32'hFFFF_FFFF, 4'b0000, 32'h0,         "write_nosel");
    add_vec(1, 0, 32'h0000_0024, 32'h0,         4'b0000, 32'h8877_6655, "read_24");
    add_vec(1, 1, 32'h0000_002A, 32'h1234_5678, 4'b1111, 32'h0,         "write_full");
    add_vec(0, 0, 32'h0000_0028, 32'h0,         4'b0000, 32'h1234_5678, "fetch_28");
    add_vec(0, 0, 32'h0002_0010, 32'h0,         4'b0000, 32'h0000_0513, "fetch_wrap");
    add_vec(1, 1, 32'h0000_0028, 32'hA000_0000, 4'b1000, 32'h0,         "write_top");
    add_vec(1, 0, 32'h0000_0029, 32'h0,         4'b0000, 32'hA034_5678, "read_29");

    foreach (vecs[i]) begin
      run_txn(vecs[i].is_mem, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sel, got);
      if (!vecs[i].we) check(vecs[i].name, got, vecs[i].exp);
    end

    check("ram_20", 32'(ram[17'h20]), 32'hDD);
    check("ram_21", 32'(ram[17'h21]), 32'h22);
    check("ram_22", 32'(ram[17'h22]), 32'hBB);
    check("ram_23", 32'(ram[17'h23]), 32'h44);
    check("ram_24_kept", 32'(ram[17'h24]), 32'h55);

    // Upper address bits discarded; byte addresses walk the word.
    run_txn(0, 0, 32'h0002_0007, 32'h0, 4'b0000, got);
    check("fetch_20007", got, 32'h0EE9_C49F);
    for (int k = 0; k < 4; k++) check("addr_seq", 32'(addr_log[k]), 32'(4 + k));

    // Simultaneous requests: data port first, fetch after one idle cycle.
    if_req   = 1'b1;
    if_addr  = 32'h10;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h20;
    wait_done(1, lat, got, other);
    mem_req = 1'b0;
    check("both_mem_latency", 32'(lat), 32'd6);
    check("both_mem_first", 32'(other), 32'd0);
    check("both_mem_data", got, 32'h44BB_22DD);
    wait_done(0, lat, got, other);
    if_req = 1'b0;
    check("both_if_latency", 32'(lat), 32'd7);
    check("both_if_data", got, 32'h0000_0513);
    tick();
    last_mem = model_word(32'h20);
    last_if  = model_word(32'h10);
    check("both_if_hold", if_inst, last_if);

    // Reset in the third read cycle abandons the fetch; held request restarts it.
    if_req   = 1'b1;
    if_addr  = 32'h24;
    any_done = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      any_done = any_done | if_done | mem_done;
    end
    rst = 1'b1;
    tick();
    any_done = any_done | if_done | mem_done;
    check("rst_mid_no_done", 32'(any_done), 32'd0);
    check("rst_mid_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_mid_ram_we", 32'(ram_we), 32'd0);
    check("rst_mid_if_inst", if_inst, 32'd0);
    check("rst_mid_mem_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    wait_done(0, lat, got, other);
    if_req = 1'b0;
    check("rst_retry_latency", 32'(lat), 32'd6);
    check("rst_retry_data", got, 32'h8877_6655);
    tick();
    last_if  = model_word(32'h24);
    last_mem = '0;
    check("rst_retry_mem_hold", mem_rdata, last_mem);

    // Random traffic over a small window so writes and reads collide.
    for (int i = 0; i < 60; i++) begin
      bit          m;
      bit          w;
      logic [31:0] a;
      logic [31:0] expw;
      m = 1'($urandom_range(0, 1));
      w = m && (1'($urandom_range(0, 1)));
      a = ($urandom & 32'hFFFE_0000) | (32'h100 + 32'($urandom_range(0, 63)));
      expw = model_word(a);
      run_txn(m, w, a, $urandom, 4'($urandom), got);
      if (!w) check("rand_read", got, expw);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
